fwnoc_router_ingress_q: RTL and testbench
=========================================

Name: fwnoc_router_ingress_q

Overview:
- Parametrised next-generation router ingress port for the fwnoc 2-D mesh.
- Buffers incoming flits in a DEPTH-entry FIFO, decodes the header and selects one of five egress directions (host/N/S/E/W) by dimension-order XY routing.
- Forwards the header and all payload flits of the packet to that direction wormhole-style, then releases the port.
- One instance sits on each router input; its five initiator ports feed the router's per-direction egress arbiters.

Parameters:
- X_ID, 0, this router's X coordinate.
- Y_ID, 0, this router's Y coordinate.
- DAT_W, 32, flit width in bits (>= 2*XY_W+SZ_W).
- XY_W, 2, width of each destination coordinate field.
- SZ_W, 4, width of the payload-length field.
- DEPTH, 4, ingress FIFO entries (power of 2, >= 2).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_dat  in  DAT_W  ingress flit.
- i_valid  in  1  ingress flit valid.
- i_ready  out  1  ingress ready; equals FIFO not full.
- he_dat, ne_dat, se_dat, ee_dat, we_dat  out  DAT_W each  egress flit (host/north/south/east/west).
- he_valid, ne_valid, se_valid, ee_valid, we_valid  out  1 each  egress valid.
- he_ready, ne_ready, se_ready, ee_ready, we_ready  in  1 each  egress ready.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- busy  out  1  high while a packet is routed (states HDR/BODY).

Behaviour:
- Header format: dst_x = dat[DAT_W-1 -: XY_W]; dst_y = next XY_W bits below dst_x; payload length N = dat[SZ_W-1:0]. Packet = header + N payload flits; N = 0 means header-only.
- Handshake: a transfer occurs on a rising edge with valid && ready. Once valid is asserted, it holds with dat stable until the transfer.
- FIFO
  - Push on i_valid && i_ready; pop on a handshake at the selected egress port.
  - Push and pop in the same cycle are legal and leave count unchanged.
  - Full: i_ready = 0. No bypass; a flit written at edge k is visible at the FIFO head after edge k.
  - Read and write pointers wrap modulo DEPTH.
- All five *_dat outputs are driven by the FIFO head. Only the selected port's valid may be high; the other four are 0.
- FSM states:
  - IDLE: busy = 0, all egress valid = 0. If FIFO is non-empty, latch dst_x, dst_y and N from the head, compute sel, latch rem = N, and go to HDR.
  - Route computation, in priority order:
    - dst_x == X_ID && dst_y == Y_ID -> host.
    - dst_x > X_ID -> east.
    - dst_x < X_ID -> west.
    - dst_y > Y_ID -> north.
    - else -> south.
    - Compare unsigned, XY_W bits.
  - HDR: sel_valid = 1 (FIFO holds the header). On handshake, pop; if rem == 0 go to IDLE, else go to BODY.
  - BODY: sel_valid = FIFO non-empty. A starved wormhole drops valid; a later flit re-asserts it. On handshake, pop and decrement rem; when rem == 1 at the handshake, go to IDLE.
- Latency: header accepted at edge k into an empty FIFO -> sel_valid is high after edge k+1 (one cycle of route decode). Back-to-back packets: after the last flit's handshake, the FSM spends one IDLE cycle before the next header is presented.
- sel and rem stay constant from HDR entry until return to IDLE. Egress ready on non-selected ports is ignored.
- Reset (reset == 0, any time, including mid-packet):
  - Immediately: all egress valid = 0, busy = 0, count = 0, i_ready = 0 while reset is asserted, state = IDLE, FIFO pointers cleared.
  - Any partial packet is dropped.
  - After deassertion, i_ready = 1 on the first cycle.

Test Plan:
- Local delivery: X_ID=1, Y_ID=2, DAT_W=32; send header 0x6000_0002 plus payloads 0xA, 0xB with all readies high -> he_valid high after edge k+1; he_dat sequence 0x6000_0002, 0xA, 0xB; other valids stay 0; busy falls after the third handshake.
- XY routing: from (1,1), headers with dst (3,0), (0,3), (1,3), (1,0), N=0 -> egress is east, west, north, south respectively; X is resolved before Y.
- Backpressure/full: DEPTH=4, ee_ready=0, push 6 flits of an east packet -> i_ready drops after 4 accepted, count=4; raise ee_ready -> remaining flits flow, count never exceeds 4, order preserved.
- Starved wormhole: header N=3 followed by a 5-cycle gap before the payloads -> the selected valid drops during the gap, the FSM stays in BODY, and exactly 3 payloads are forwarded before IDLE.
- Back-to-back packets: two header-only packets to different ports with continuous input -> the second port's valid rises exactly one IDLE cycle after the first handshake; simultaneous push and pop keep count steady.
- Reset mid-packet: assert reset during BODY with rem=2 -> all valids, count and busy go to 0 asynchronously; after release a new header routes correctly with no leftover payload emitted.

Source files
------------

// File: rtl/fwnoc_router_ingress_q_if.sv
// Ingress/egress flit handshake bundle for one fwnoc router input port.
// The slave side is the ingress queue; the master side is the feeder plus egress arbiters.
interface fwnoc_router_ingress_q_if #(
  parameter int DAT_W = 32
);
  logic [DAT_W-1:0] i_dat;
  logic             i_valid;
  logic             i_ready;
  logic [DAT_W-1:0] he_dat, ne_dat, se_dat, ee_dat, we_dat;
  logic             he_valid, ne_valid, se_valid, ee_valid, we_valid;
  logic             he_ready, ne_ready, se_ready, ee_ready, we_ready;

  modport slave (
    input  i_dat, i_valid,
    output i_ready,
    output he_dat, ne_dat, se_dat, ee_dat, we_dat,
    output he_valid, ne_valid, se_valid, ee_valid, we_valid,
    input  he_ready, ne_ready, se_ready, ee_ready, we_ready
  );

  modport master (
    output i_dat, i_valid,
    input  i_ready,
    input  he_dat, ne_dat, se_dat, ee_dat, we_dat,
    input  he_valid, ne_valid, se_valid, ee_valid, we_valid,
    output he_ready, ne_ready, se_ready, ee_ready, we_ready
  );
endinterface

// File: rtl/fwnoc_router_ingress_q.sv
// fwnoc mesh router ingress: DEPTH-entry flit FIFO, XY route decode of the header,
// wormhole forwarding of header + N payload flits to one of five egress ports.
module fwnoc_router_ingress_q #(
  parameter int X_ID  = 0,
  parameter int Y_ID  = 0,
  parameter int DAT_W = 32,
  parameter int XY_W  = 2,
  parameter int SZ_W  = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  fwnoc_router_ingress_q_if.slave  bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]     FULL = (AW+1)'(DEPTH);
  localparam logic [XY_W-1:0] XC   = XY_W'(X_ID);
  localparam logic [XY_W-1:0] YC   = XY_W'(Y_ID);
  // egress index order: host, north, south, east, west
  localparam logic [2:0] P_H = 3'd0, P_N = 3'd1, P_S = 3'd2, P_E = 3'd3, P_W = 3'd4;

  typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

  state_t            state, state_nxt;
  logic [DAT_W-1:0]  mem [DEPTH];
  logic [AW-1:0]     wp, rp;
  logic [DAT_W-1:0]  head;
  logic [XY_W-1:0]   dst_x, dst_y;
  logic [2:0]        route, sel;
  logic [SZ_W-1:0]   rem;
  logic [4:0]        rdy, vld;
  logic              sel_valid, push, pop, nonempty;

  assign head     = mem[rp];
  assign dst_x    = head[DAT_W-1 -: XY_W];
  assign dst_y    = head[DAT_W-1-XY_W -: XY_W];
  assign nonempty = (count != '0);
  assign bus.i_ready = reset && (count != FULL);
  assign push     = bus.i_valid && bus.i_ready;
  assign busy     = (state != IDLE);

  // X is resolved before Y
  always_comb begin
    if (dst_x == XC && dst_y == YC) route = P_H;
    else if (dst_x > XC)            route = P_E;
    else if (dst_x < XC)            route = P_W;
    else if (dst_y > YC)            route = P_N;
    else                            route = P_S;
  end

  assign rdy = {bus.we_ready, bus.ee_ready, bus.se_ready, bus.ne_ready, bus.he_ready};

  always_comb begin
    state_nxt = state;
    sel_valid = 1'b0;
    case (state)
      IDLE: if (nonempty) state_nxt = HDR;
      HDR: begin
        sel_valid = 1'b1;
        if (rdy[sel]) state_nxt = (rem == '0) ? IDLE : BODY;
      end
      BODY: begin
        sel_valid = nonempty;
        if (sel_valid && rdy[sel] && rem == SZ_W'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pop = sel_valid && rdy[sel];

  always_comb begin
    vld      = '0;
    vld[sel] = sel_valid;
  end

  assign {bus.we_valid, bus.ee_valid, bus.se_valid, bus.ne_valid, bus.he_valid} = vld;
  assign bus.he_dat = head;
  assign bus.ne_dat = head;
  assign bus.se_dat = head;
  assign bus.ee_dat = head;
  assign bus.we_dat = head;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sel   <= P_H;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && nonempty) begin
        sel <= route;
        rem <= head[SZ_W-1:0];
      end else if (state == BODY && pop) begin
        rem <= rem - SZ_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wp] <= bus.i_dat;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end
endmodule

// File: tb/tb_fwnoc_router_ingress_q.sv
// Directed bench for fwnoc_router_ingress_q at router (1,2), DEPTH=4.
// Egress index: 0 host, 1 north, 2 south, 3 east, 4 west.
module tb_fwnoc_router_ingress_q;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] count;
  logic       busy;
  int         total = 0;
  int         bad   = 0;
  logic [31:0] src [8];

  fwnoc_router_ingress_q_if #(.DAT_W(32)) bus ();

  fwnoc_router_ingress_q #(
    .X_ID(1), .Y_ID(2), .DAT_W(32), .XY_W(2), .SZ_W(4), .DEPTH(4)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus), .count(count), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic cyc;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] hdr(input int x, input int y, input int n);
    logic [31:0] xv, yv, nv;
    xv = x; yv = y; nv = n;
    return {xv[1:0], yv[1:0], 24'h0, nv[3:0]};
  endfunction

  function automatic logic [4:0] vv();
    return {bus.we_valid, bus.ee_valid, bus.se_valid, bus.ne_valid, bus.he_valid};
  endfunction

  function automatic logic [31:0] pd(input int p);
    case (p)
      0: return bus.he_dat;
      1: return bus.ne_dat;
      2: return bus.se_dat;
      3: return bus.ee_dat;
      default: return bus.we_dat;
    endcase
  endfunction

  function automatic logic pr(input int p);
    case (p)
      0: return bus.he_ready;
      1: return bus.ne_ready;
      2: return bus.se_ready;
      3: return bus.ee_ready;
      default: return bus.we_ready;
    endcase
  endfunction

  task automatic set_rdy(input logic [4:0] r);
    {bus.we_ready, bus.ee_ready, bus.se_ready, bus.ne_ready, bus.he_ready} = r;
  endtask

  // Push src[in_i..in_to-1] while checking egress 'port' emits src[out_i..out_to-1] in order.
  task automatic stream(input int in_i, input int in_to, input int out_i, input int out_to,
                        input int port, input string tag);
    logic acc_in, acc_out;
    int   ii, oi;
    ii = in_i; oi = out_i;
    if (ii < in_to) begin bus.i_dat = src[ii]; bus.i_valid = 1'b1; end
    for (int c = 0; c < 60 && oi < out_to; c++) begin
      acc_in  = bus.i_valid && bus.i_ready;
      acc_out = vv()[port] && pr(port);
      if (acc_out) begin
        chk({tag, "_order"}, pd(port), src[oi]);
        oi++;
      end
      cyc;
      chk({tag, "_cnt_le4"}, 32'(count > 3'd4), 32'd0);
      if (acc_in) begin
        ii++;
        if (ii < in_to) bus.i_dat = src[ii];
        else            bus.i_valid = 1'b0;
      end
    end
    chk({tag, "_all_out"}, 32'(oi), 32'(out_to));
  endtask

  logic [31:0] rt_h [5];
  logic [4:0]  rt_v [5];

  initial begin
    bus.i_dat = '0; bus.i_valid = 1'b0;
    set_rdy(5'b11111);

    // reset state
    #2;
    chk("rst_iready", 32'(bus.i_ready), 32'd0);
    chk("rst_count",  32'(count), 32'd0);
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_valid",  32'(vv()), 32'd0);
    cyc; cyc;
    reset = 1'b1;
    #1;
    chk("rel_iready", 32'(bus.i_ready), 32'd1);

    // local delivery: (1,2) header with 2 payloads
    bus.i_dat = 32'h6000_0002; bus.i_valid = 1'b1;
    cyc;
    chk("loc_no_valid_k", 32'(vv()), 32'd0);
    bus.i_dat = 32'hA;
    cyc;
    chk("loc_valid_k1", 32'(vv()), 32'b00001);
    chk("loc_dat_hdr",  bus.he_dat, 32'h6000_0002);
    bus.i_dat = 32'hB;
    cyc;
    bus.i_valid = 1'b0;
    chk("loc_dat_a", bus.he_dat, 32'hA);
    chk("loc_busy_a", 32'(busy), 32'd1);
    cyc;
    chk("loc_dat_b", bus.he_dat, 32'hB);
    chk("loc_valid_b", 32'(vv()), 32'b00001);
    cyc;
    chk("loc_busy_end", 32'(busy), 32'd0);
    chk("loc_valid_end", 32'(vv()), 32'd0);
    chk("loc_count_end", 32'(count), 32'd0);

    // XY routing, header-only
    rt_h[0] = hdr(3, 0, 0); rt_v[0] = 5'b01000;
    rt_h[1] = hdr(0, 3, 0); rt_v[1] = 5'b10000;
    rt_h[2] = hdr(1, 3, 0); rt_v[2] = 5'b00010;
    rt_h[3] = hdr(1, 0, 0); rt_v[3] = 5'b00100;
    rt_h[4] = hdr(3, 3, 0); rt_v[4] = 5'b01000;
    for (int i = 0; i < 5; i++) begin
      bus.i_dat = rt_h[i]; bus.i_valid = 1'b1;
      cyc;
      bus.i_valid = 1'b0;
      cyc;
      chk($sformatf("xy_route%0d", i), 32'(vv()), 32'(rt_v[i]));
      cyc;
      chk($sformatf("xy_done%0d", i), 32'({busy, vv(), count}), 32'd0);
    end

    // backpressure: east packet of 6 flits, ee_ready held low
    set_rdy(5'b10111);
    src[0] = hdr(3, 2, 5);
    for (int i = 1; i < 6; i++) src[i] = 32'h100 + 32'(i);
    for (int i = 0; i < 4; i++) begin
      bus.i_dat = src[i]; bus.i_valid = 1'b1;
      cyc;
    end
    bus.i_dat = src[4];
    chk("bp_iready_full", 32'(bus.i_ready), 32'd0);
    chk("bp_count_full",  32'(count), 32'd4);
    chk("bp_east_valid",  32'(vv()), 32'b01000);
    cyc; cyc;
    chk("bp_count_hold", 32'(count), 32'd4);
    set_rdy(5'b11111);
    stream(4, 6, 0, 6, 3, "bp");
    chk("bp_busy_end",  32'(busy), 32'd0);
    chk("bp_count_end", 32'(count), 32'd0);

    // starved wormhole: west header N=3, 5-cycle gap
    bus.i_dat = hdr(0, 2, 3); bus.i_valid = 1'b1;
    cyc;
    bus.i_valid = 1'b0;
    cyc;
    chk("sw_hdr_valid", 32'(vv()), 32'b10000);
    cyc;
    for (int g = 0; g < 5; g++) begin
      chk($sformatf("sw_gap_valid%0d", g), 32'(vv()), 32'd0);
      chk($sformatf("sw_gap_busy%0d", g), 32'(busy), 32'd1);
      if (g < 4) cyc;
    end
    src[0] = 32'h201; src[1] = 32'h202; src[2] = 32'h203;
    stream(0, 3, 0, 3, 4, "sw");
    chk("sw_busy_end", 32'(busy), 32'd0);

    // back-to-back header-only packets: E, W, N
    bus.i_dat = hdr(3, 1, 0); bus.i_valid = 1'b1;
    cyc;
    bus.i_dat = hdr(0, 1, 0);
    cyc;
    bus.i_dat = hdr(1, 3, 0);
    chk("b2b_first_e", 32'(vv()), 32'b01000);
    chk("b2b_count2",  32'(count), 32'd2);
    cyc;
    bus.i_valid = 1'b0;
    chk("b2b_idle_gap",   32'(vv()), 32'd0);
    chk("b2b_count_same", 32'(count), 32'd2);
    cyc;
    chk("b2b_second_w", 32'(vv()), 32'b10000);
    cyc;
    chk("b2b_gap2", 32'(vv()), 32'd0);
    cyc;
    chk("b2b_third_n", 32'(vv()), 32'b00010);
    cyc;
    chk("b2b_done", 32'({busy, count}), 32'd0);

    // reset mid-packet: south header N=3, hold in BODY with rem=2
    bus.i_dat = hdr(1, 0, 3); bus.i_valid = 1'b1;
    cyc;
    bus.i_dat = 32'h301;
    cyc;
    bus.i_dat = 32'h302;
    cyc;
    bus.i_valid = 1'b0;
    cyc;
    set_rdy(5'b11011);
    chk("mr_pre_busy",  32'(busy), 32'd1);
    chk("mr_pre_count", 32'(count), 32'd1);
    chk("mr_pre_valid", 32'(vv()), 32'b00100);
    #2 reset = 1'b0;
    #1;
    chk("mr_valid0",  32'(vv()), 32'd0);
    chk("mr_count0",  32'(count), 32'd0);
    chk("mr_busy0",   32'(busy), 32'd0);
    chk("mr_iready0", 32'(bus.i_ready), 32'd0);
    cyc; cyc;
    reset = 1'b1;
    set_rdy(5'b11111);
    #1;
    chk("mr_iready1", 32'(bus.i_ready), 32'd1);
    bus.i_dat = hdr(3, 2, 0); bus.i_valid = 1'b1;
    cyc;
    bus.i_valid = 1'b0;
    chk("mr_no_leftover", 32'(vv()), 32'd0);
    cyc;
    chk("mr_new_route", 32'(vv()), 32'b01000);
    chk("mr_new_dat",   bus.ee_dat, hdr(3, 2, 0));
    cyc;
    chk("mr_new_done", 32'({busy, vv(), count}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
